// File: rtl/seg_scan_reader.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_reader
// Description : Reads back a multiplexed, scanned 7-segment display bus and
//               rebuilds the hex nibble shown on each digit. Inputs are
//               synchronized, held until stable, inverse-mapped through the
//               team segment table, and a one-cycle pulse marks each frame in
//               which every digit has been captured.
// Ports       : clk         - system clock
//               rst         - asynchronous reset, active-high
//               seg_in      - segment lines a..g on bits 0..6, active-high
//               an_in       - digit enables, active-high, expected one-hot
//               nibbles_out - decoded nibbles, digit i at [4i+3:4i]
//               blank_out   - digit i last captured with all segments off
//               err_out     - digit i last captured with an unknown pattern
//               frame_valid - one-cycle pulse when all digits were captured
// Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_reader #(
  parameter int NDIG   = 4,
  parameter int STABLE = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [6:0]           seg_in,
  input  logic [NDIG-1:0]      an_in,
  output logic [4*NDIG-1:0]    nibbles_out,
  output logic [NDIG-1:0]      blank_out,
  output logic [NDIG-1:0]      err_out,
  output logic                 frame_valid
);

  localparam int SW = NDIG + 7;
  localparam int CW = $clog2(STABLE + 1);
  localparam logic [CW-1:0] C_CNT_MAX = CW'(STABLE);
  localparam logic [CW-1:0] C_CNT_CAP = CW'(STABLE - 1);

  // Returns {hit, nibble}; hit is clear for any pattern outside the table.
  function automatic logic [4:0] seg_decode(input logic [6:0] seg);
    logic [4:0] r;
    r = 5'h00;
    case (seg)
      7'h3F: r = {1'b1, 4'h0};
      7'h06: r = {1'b1, 4'h1};
      7'h5B: r = {1'b1, 4'h2};
      7'h4F: r = {1'b1, 4'h3};
      7'h66: r = {1'b1, 4'h4};
      7'h6D: r = {1'b1, 4'h5};
      7'h7D: r = {1'b1, 4'h6};
      7'h07: r = {1'b1, 4'h7};
      7'h7F: r = {1'b1, 4'h8};
      7'h6F: r = {1'b1, 4'h9};
      7'h77: r = {1'b1, 4'hA};
      7'h74: r = {1'b1, 4'hB};
      7'h7A: r = {1'b1, 4'hC};
      7'h5E: r = {1'b1, 4'hD};
      7'h79: r = {1'b1, 4'hE};
      7'h71: r = {1'b1, 4'hF};
      default: r = 5'h00;
    endcase
    return r;
  endfunction

  logic [SW-1:0]     sync1_q, sync2_q;
  logic [SW-1:0]     held_q, held_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [NDIG-1:0]   seen_q, seen_d;
  logic [4*NDIG-1:0] nibbles_q, nibbles_d;
  logic [NDIG-1:0]   blank_q, blank_d;
  logic [NDIG-1:0]   err_q, err_d;
  logic              frame_valid_q, frame_valid_d;

  logic [NDIG-1:0]   held_an;
  logic [6:0]        held_seg;
  logic              same;
  logic              an_onehot;
  logic              capture;
  logic [4:0]        dec;
  logic [3:0]        cap_nib;
  logic              cap_blank;
  logic              cap_err;
  logic              frame_full;

  always_comb begin
    held_an  = held_q[SW-1:7];
    held_seg = held_q[6:0];
    same     = (sync2_q == held_q);

    held_d = held_q;
    cnt_d  = cnt_q;
    if (!same) begin
      held_d = sync2_q;
      cnt_d  = '0;
    end else if (cnt_q < C_CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end

    an_onehot = (held_an != '0) && ((held_an & (held_an - NDIG'(1))) == '0);
    // The STABLE-1 -> STABLE step happens once per stable period, so a
    // saturated counter never re-captures an unchanged value.
    capture = same && (cnt_q == C_CNT_CAP) && an_onehot;

    dec       = seg_decode(held_seg);
    cap_nib   = dec[4] ? dec[3:0] : 4'h0;
    cap_blank = !dec[4] && (held_seg == 7'h00);
    cap_err   = !dec[4] && (held_seg != 7'h00);

    // The frame pulse follows the edge at which seen filled up; a capture on
    // the clearing edge belongs to the new frame.
    frame_full    = &seen_q;
    frame_valid_d = frame_full;
    seen_d        = frame_full ? '0 : seen_q;

    nibbles_d = nibbles_q;
    blank_d   = blank_q;
    err_d     = err_q;
    for (int i = 0; i < NDIG; i++) begin
      if (capture && held_an[i]) begin
        seen_d[i]           = 1'b1;
        nibbles_d[4*i +: 4] = cap_nib;
        blank_d[i]          = cap_blank;
        err_d[i]            = cap_err;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q       <= '0;
      sync2_q       <= '0;
      held_q        <= '0;
      cnt_q         <= '0;
      seen_q        <= '0;
      nibbles_q     <= '0;
      blank_q       <= '0;
      err_q         <= '0;
      frame_valid_q <= 1'b0;
    end else begin
      sync1_q       <= {an_in, seg_in};
      sync2_q       <= sync1_q;
      held_q        <= held_d;
      cnt_q         <= cnt_d;
      seen_q        <= seen_d;
      nibbles_q     <= nibbles_d;
      blank_q       <= blank_d;
      err_q         <= err_d;
      frame_valid_q <= frame_valid_d;
    end
  end

  assign nibbles_out = nibbles_q;
  assign blank_out   = blank_q;
  assign err_out     = err_q;
  assign frame_valid = frame_valid_q;

endmodule
`default_nettype wire

// File: doc/seg_scan_reader.md
Name: seg_scan_reader

Overview:
- Reads back a multiplexed, scanned 7-segment display bus and rebuilds the hex nibble shown on each digit.
- It is the decoder-side counterpart of the team's hex-to-segment converter.
- Used for loopback self-test of the display path and for capturing display values driven by an external board.
- Inputs are synchronized and debounced, patterns are inverse-mapped through the team segment table, and a one-cycle pulse marks each completed frame.

Parameters:
- NDIG, 4, number of scanned digits (1..8).
- STABLE, 4, consecutive identical synchronized cycles required before a digit is captured (1..255).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- seg_in  in  7  segment lines, active-high. Bit0=a, bit1=b, bit2=c, bit3=d, bit4=e, bit5=f, bit6=g.
- an_in  in  NDIG  digit enables, active-high, expected one-hot.
- nibbles_out  out  4*NDIG  decoded nibbles; digit i occupies [4i+3:4i].
- blank_out  out  NDIG  digit i last captured as all segments off.
- err_out  out  NDIG  digit i last captured as a pattern not in the table.
- frame_valid  out  1  one-cycle pulse when every digit has been captured since the last pulse.

Behaviour:
- Team segment table, seg_in value to nibble:
  - 0x3F→0, 0x06→1, 0x5B→2, 0x4F→3, 0x66→4, 0x6D→5, 0x7D→6, 0x07→7
  - 0x7F→8, 0x6F→9, 0x77→A, 0x74→B, 0x7A→C, 0x5E→D, 0x79→E, 0x71→F
- Synchronization: {an_in, seg_in} passes through a 2-flop synchronizer, giving sync2.
- Stability tracking:
  - Register held holds the last sync2 value; cnt is a saturating counter, width clog2(STABLE+1).
  - Each edge: if sync2 != held, then held <= sync2 and cnt <= 0. Otherwise, if cnt < STABLE, cnt <= cnt+1.
- Capture:
  - Occurs on the edge where cnt goes from STABLE-1 to STABLE, and only if held.an is exactly one-hot.
  - Exactly one capture per stable period. No re-capture while the value stays unchanged, since cnt is saturated.
  - Latency: a new value first sampled by sync stage 1 at edge N is visible on the outputs after edge N+2+STABLE.
- On capture for digit i, at that same edge:
  - Table hit: nibble_i <= table value, blank_i <= 0, err_i <= 0.
  - seg == 0x00: nibble_i <= 0, blank_i <= 1, err_i <= 0.
  - Any other pattern: nibble_i <= 0, blank_i <= 0, err_i <= 1.
  - seen[i] <= 1 in every case.
- Non-one-hot an (zero bits set or more than one): no capture, no output change. cnt still counts, so a later change to a one-hot value restarts the stability window.
- Frame completion:
  - When seen becomes all-ones at an edge, frame_valid = 1 on the following cycle and seen clears at that same edge.
  - A capture that coincides with that clear sets its seen bit in the new frame; it is not lost.
- Re-captures: a digit captured twice within one frame overwrites its outputs; seen is unchanged.
- Reset (asynchronous, any time, including mid-window):
  - Cleared: sync flops, held, cnt, seen, nibbles_out, blank_out, err_out, frame_valid, all to 0.
  - After release, capture again needs a full 2+STABLE cycles of stable input.
- Output stability: nibbles_out, blank_out and err_out are registered and change only on capture edges.

Test Plan:
- STABLE=4, NDIG=4; drive an=0001 with seg=0x5B, held from edge 0 → nibbles_out[3:0]=2 after edge 6, err_out=0, blank_out=0; nothing before edge 6.
- Scan digits 0..3 with seg 0x06, 0x4F, 0x77, 0x71, each held 8 cycles → nibbles_out=16'hFA31; frame_valid exactly one cycle, one cycle after digit 3 is captured.
- Glitch: seg=0x3F held 3 cycles, then 0x7F held 10 cycles on an=0010 → digit1=8 captured once; 0 never captured.
- an=0110 with seg=0x07 held 20 cycles → no output change, no frame_valid. seg=0x00 on an=0100 → blank_out[2]=1. seg=0x41 on an=1000 → err_out[3]=1, nibble 0.
- Assert rst for 1 cycle mid-window (cnt=2) during a full scan → all outputs 0 immediately; the next capture occurs 2+STABLE cycles after release.
- Loopback: drive seg_in from the team hex-to-segment converter for all 16 nibbles → every value recovered exactly; err_out stays 0 throughout.
